synth_voice_allocator: RTL and testbench



---
 rtl/synth_pkg.sv | 9 +
 rtl/synth_voice_allocator_if.sv | 11 +
 rtl/synth_voice_envelope.sv | 64 ++++++
 rtl/synth_voice_allocator.sv | 107 ++++++++++
 tb/tb_synth_voice_allocator.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: shared types and widths for the voice allocator and its envelopes.
package synth_pkg;
    typedef enum logic [1:0] {ENV_IDLE, ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE} env_state_t;
    typedef enum logic [1:0] {CTL_IDLE, CTL_SCAN, CTL_COMMIT} ctl_state_t;
    localparam int VOICE_CNT = 8;
    localparam int VOL_W = 32;
    localparam int FREQ_W = 32;
    localparam int NOTE_W = 7;
endpackage

// File: rtl/synth_voice_allocator_if.sv
// synth_voice_allocator_if: note event valid/ready channel from keyboard to allocator.
interface synth_voice_allocator_if;
    import synth_pkg::*;
    logic evt_valid;
    logic evt_ready;
    logic evt_on;
    logic [NOTE_W-1:0] evt_note;
    logic [FREQ_W-1:0] evt_freq;
    modport master (output evt_valid, evt_on, evt_note, evt_freq, input evt_ready);
    modport slave (input evt_valid, evt_on, evt_note, evt_freq, output evt_ready);
endinterface

// File: rtl/synth_voice_envelope.sv
// synth_voice_envelope: one voice slot holding note/freq/age and a linear attack/sustain/release envelope.
module synth_voice_envelope import synth_pkg::*; #(
    parameter logic [VOL_W-1:0] VOL_MAX = 32'h0000_FFFF,
    parameter logic [VOL_W-1:0] ATTACK_STEP = 32'h0000_1000,
    parameter logic [VOL_W-1:0] RELEASE_STEP = 32'h0000_0800
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic load,
    input  logic retrig,
    input  logic rel,
    input  logic age_inc,
    input  logic age_clr,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [FREQ_W-1:0] freq_in,
    output env_state_t env,
    output logic [NOTE_W-1:0] note,
    output logic [FREQ_W-1:0] freq,
    output logic [VOL_W-1:0] vol,
    output logic [7:0] age
);
    logic [VOL_W:0] up;
    logic top_hit, rel_end;
    assign up = {1'b0, vol} + {1'b0, ATTACK_STEP};
    assign top_hit = up >= {1'b0, VOL_MAX};
    assign rel_end = vol <= RELEASE_STEP;
    // A commit strobe takes precedence over the envelope step in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            env <= ENV_IDLE;
            note <= '0;
            freq <= '0;
            vol <= '0;
            age <= '0;
        end else begin
            if (load || retrig) begin
                env <= ENV_ATTACK;
                freq <= freq_in;
                if (load) begin
                    note <= note_in;
                    vol <= '0;
                end
            end else if (rel) begin
                env <= ENV_RELEASE;
            end else if (tick) begin
                case (env)
                    ENV_ATTACK: begin
                        vol <= top_hit ? VOL_MAX : up[VOL_W-1:0];
                        if (top_hit) env <= ENV_SUSTAIN;
                    end
                    ENV_RELEASE: begin
                        vol <= rel_end ? '0 : vol - RELEASE_STEP;
                        if (rel_end) env <= ENV_IDLE;
                    end
                    ENV_IDLE: vol <= '0;
                    default: ;
                endcase
            end
            if (age_clr) age <= '0;
            else if (age_inc && age != 8'hFF) age <= age + 8'd1;
        end
    end
endmodule

// File: rtl/synth_voice_allocator.sv
// synth_voice_allocator: assigns note events to voice slots (reuse, free, else steal oldest)
// via a serial scan, and exposes per-voice frequency/volume to the synthesizer.
module synth_voice_allocator import synth_pkg::*; #(
    parameter int VOICES = VOICE_CNT,
    parameter logic [VOL_W-1:0] VOL_MAX = 32'h0000_FFFF,
    parameter logic [VOL_W-1:0] ATTACK_STEP = 32'h0000_1000,
    parameter logic [VOL_W-1:0] RELEASE_STEP = 32'h0000_0800
) (
    input  logic clk,
    input  logic reset,
    synth_voice_allocator_if.slave bus,
    input  logic tick,
    output logic [VOICES-1:0][FREQ_W-1:0] frequencies,
    output logic [VOICES-1:0][VOL_W-1:0] voice_volumes,
    output logic [VOICES-1:0] voice_busy
);
    localparam int IW = VOICES > 1 ? $clog2(VOICES) : 1;
    ctl_state_t st;
    logic [IW-1:0] idx, match_idx, free_idx, old_idx, tgt;
    logic match_found, free_found, old_found, ev_on, commit, hit;
    logic [7:0] old_age;
    logic [NOTE_W-1:0] ev_note;
    logic [FREQ_W-1:0] ev_freq;
    env_state_t env [VOICES];
    logic [NOTE_W-1:0] note [VOICES];
    logic [FREQ_W-1:0] freq [VOICES];
    logic [VOL_W-1:0] vol [VOICES];
    logic [7:0] age [VOICES];
    assign bus.evt_ready = st == CTL_IDLE && !reset;
    assign commit = st == CTL_COMMIT;
    assign tgt = match_found ? match_idx : free_found ? free_idx : old_idx;
    // Releasing voices still match a repeated note-on so it retriggers instead of doubling.
    assign hit = env[idx] != ENV_IDLE && note[idx] == ev_note && (env[idx] != ENV_RELEASE || ev_on);
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= CTL_IDLE;
            idx <= '0;
            match_found <= 1'b0;
            free_found <= 1'b0;
            old_found <= 1'b0;
            match_idx <= '0;
            free_idx <= '0;
            old_idx <= '0;
            old_age <= '0;
            ev_on <= 1'b0;
            ev_note <= '0;
            ev_freq <= '0;
        end else begin
            case (st)
                CTL_IDLE: if (bus.evt_valid) begin
                    st <= CTL_SCAN;
                    idx <= '0;
                    match_found <= 1'b0;
                    free_found <= 1'b0;
                    old_found <= 1'b0;
                    ev_on <= bus.evt_on;
                    ev_note <= bus.evt_note;
                    ev_freq <= bus.evt_freq;
                end
                CTL_SCAN: begin
                    if (!match_found && hit) begin
                        match_found <= 1'b1;
                        match_idx <= idx;
                    end
                    if (!free_found && env[idx] == ENV_IDLE) begin
                        free_found <= 1'b1;
                        free_idx <= idx;
                    end
                    if (env[idx] != ENV_IDLE && (!old_found || age[idx] > old_age)) begin
                        old_found <= 1'b1;
                        old_idx <= idx;
                        old_age <= age[idx];
                    end
                    idx <= idx + 1'b1;
                    if (idx == IW'(VOICES - 1)) st <= CTL_COMMIT;
                end
                default: st <= CTL_IDLE;
            endcase
        end
    end
    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        logic sel;
        assign sel = tgt == IW'(g);
        synth_voice_envelope #(
            .VOL_MAX(VOL_MAX), .ATTACK_STEP(ATTACK_STEP), .RELEASE_STEP(RELEASE_STEP)
        ) u_env (
            .clk(clk),
            .reset(reset),
            .tick(tick),
            .load(commit && ev_on && sel && !match_found),
            .retrig(commit && ev_on && sel && match_found),
            .rel(commit && !ev_on && sel && match_found),
            .age_inc(commit && ev_on && !sel && env[g] != ENV_IDLE),
            .age_clr(commit && ev_on && sel),
            .note_in(ev_note),
            .freq_in(ev_freq),
            .env(env[g]),
            .note(note[g]),
            .freq(freq[g]),
            .vol(vol[g]),
            .age(age[g])
        );
        assign voice_busy[g] = env[g] != ENV_IDLE;
        assign frequencies[g] = voice_busy[g] ? freq[g] : '0;
        assign voice_volumes[g] = vol[g];
    end
endmodule

// File: tb/tb_synth_voice_allocator.sv
// tb_synth_voice_allocator: directed vector table plus hand sequences for commit-tick and mid-scan reset.
module tb_synth_voice_allocator;
    import synth_pkg::*;
    localparam int V = 8;
    typedef struct {
        bit ev;
        bit on;
        logic [6:0] note;
        logic [31:0] freq;
        bit hold;
        int ticks;
        int vi;
        logic [7:0] busy;
        logic [31:0] fexp;
        logic [31:0] vexp;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic [V-1:0][31:0] frequencies;
    logic [V-1:0][31:0] voice_volumes;
    logic [V-1:0] voice_busy;
    int total = 0;
    int bad = 0;
    vec_t vecs[$];
    synth_voice_allocator_if bus();
    synth_voice_allocator #(.VOICES(V)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .tick(tick),
        .frequencies(frequencies),
        .voice_volumes(voice_volumes),
        .voice_busy(voice_busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input bit on, input logic [6:0] note, input logic [31:0] f, input bit hold);
        int n = 0;
        while (!bus.evt_ready && n < 50) begin
            cyc();
            n++;
        end
        chk("accept_ready", bus.evt_ready, 1);
        bus.evt_valid = 1'b1;
        bus.evt_on = on;
        bus.evt_note = note;
        bus.evt_freq = f;
        tick = hold;
        cyc();
        bus.evt_valid = 1'b0;
        chk("scan_not_ready", bus.evt_ready, 0);
        repeat (V) cyc();
        chk("commit_not_ready", bus.evt_ready, 0);
        cyc();
        tick = 1'b0;
        chk("ready_back", bus.evt_ready, 1);
    endtask
    function automatic vec_t mk(bit ev, bit on, logic [6:0] note, logic [31:0] freq, bit hold,
                                int ticks, int vi, logic [7:0] busy, logic [31:0] fexp, logic [31:0] vexp);
        return '{ev, on, note, freq, hold, ticks, vi, busy, fexp, vexp};
    endfunction
    initial begin
        bus.evt_valid = 1'b0;
        bus.evt_on = 1'b0;
        bus.evt_note = '0;
        bus.evt_freq = '0;
        vecs.push_back(mk(1, 1, 60, 32'h1234, 0, 0, 0, 8'h01, 32'h1234, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 15, 0, 8'h01, 32'h1234, 32'hF000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h01, 32'h1234, 32'hFFFF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 8'h01, 32'h1234, 32'hFFFF));
        vecs.push_back(mk(1, 0, 60, 0, 0, 0, 0, 8'h01, 32'h1234, 32'hFFFF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 31, 0, 8'h01, 32'h1234, 32'h07FF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 32'h0, 32'h0));
        vecs.push_back(mk(1, 0, 50, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0));
        // tick held through the whole event: the commit tick must not step the loaded voice
        vecs.push_back(mk(1, 1, 60, 32'h100, 1, 0, 0, 8'h01, 32'h100, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h01, 32'h100, 32'h1000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 7, 0, 8'h01, 32'h100, 32'h8000));
        vecs.push_back(mk(1, 1, 60, 32'h200, 0, 0, 0, 8'h01, 32'h200, 32'h8000));
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(1, 1, 7'(61 + k), 32'h101 + k, 0, 0, k + 1, 8'hFF >> (6 - k), 32'h101 + k, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'hFF, 32'h200, 32'h8000));
        vecs.push_back(mk(1, 1, 68, 32'h999, 0, 0, 0, 8'hFF, 32'h999, 32'h0));
        vecs.push_back(mk(1, 1, 69, 32'h9AA, 0, 0, 1, 8'hFF, 32'h9AA, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 8'hFF, 32'h102, 32'h0));
        repeat (2) cyc();
        chk("reset_ready", bus.evt_ready, 0);
        chk("reset_busy", voice_busy, 0);
        reset = 1'b0;
        #1;
        chk("first_ready", bus.evt_ready, 1);
        foreach (vecs[i]) begin
            if (vecs[i].ev) send(vecs[i].on, vecs[i].note, vecs[i].freq, vecs[i].hold);
            else begin
                tick = 1'b1;
                repeat (vecs[i].ticks) cyc();
                tick = 1'b0;
            end
            chk($sformatf("vec%0d_busy", i), voice_busy, vecs[i].busy);
            chk($sformatf("vec%0d_freq", i), frequencies[vecs[i].vi], vecs[i].fexp);
            chk($sformatf("vec%0d_vol", i), voice_volumes[vecs[i].vi], vecs[i].vexp);
        end
        bus.evt_valid = 1'b1;
        bus.evt_on = 1'b1;
        bus.evt_note = 70;
        bus.evt_freq = 32'h777;
        cyc();
        bus.evt_valid = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        #1;
        chk("midscan_reset_ready", bus.evt_ready, 0);
        cyc();
        chk("midscan_reset_busy", voice_busy, 0);
        for (int v = 0; v < V; v++) begin
            chk($sformatf("midscan_freq%0d", v), frequencies[v], 0);
            chk($sformatf("midscan_vol%0d", v), voice_volumes[v], 0);
        end
        reset = 1'b0;
        #1;
        chk("after_reset_ready", bus.evt_ready, 1);
        repeat (V + 2) cyc();
        chk("discarded_event_busy", voice_busy, 0);
        send(1, 70, 32'h777, 0);
        chk("post_reset_busy", voice_busy, 8'h01);
        chk("post_reset_freq", frequencies[0], 32'h777);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
